glyph_row_serializer: RTL
=========================

// Module: glyph_row_serializer
// PURPOSE
//   Streams one glyph row as serial pixels for the VGA console text pipeline. Accepts
//   (char code, glyph row, attributes) on a valid/ready input and looks the glyph up
//   in an external combinational font ROM. Emits GLYPH_W pixels plus GAP blank columns,
//   each repeated by a per-glyph horizontal scale, on a valid/ready pixel stream.
//   Generalises the fixed 5x7 font lookup to a parametrised size, adds scaling,
//   inversion and underline, and supports back-to-back glyphs with no bubble cycles.
// PARAMETERS
//   GLYPH_W   5    pixel columns per glyph
//   GLYPH_H   7    pixel rows per glyph
//   GAP       1    blank columns appended after each glyph (0 allowed)
//   CODE_W    7    char code width
//   CODE_MIN  32   lowest valid code; codes < CODE_MIN render as an all-ones glyph
//   ROW_W     3    glyph row index width; must satisfy 2**ROW_W > GLYPH_H
// PORTS
//   clk           in   1               clock; all state changes on the rising edge
//   rst           in   1               synchronous reset, active-high
//   in_valid      in   1               glyph request valid
//   in_ready      out  1               request accepted when in_valid && in_ready
//   in_code       in   CODE_W          character code
//   in_row        in   ROW_W           glyph row, 0 = top
//   in_scale      in   2               horizontal repeat count minus 1 (1..4x)
//   in_invert     in   1               invert all pixels of this glyph, gap columns included
//   in_underline  in   1               row == GLYPH_H-1 forced to all ones before inversion
//   rom_addr      out  CODE_W          = in_code (combinational); ROM answers in the same cycle
//   rom_data      in   GLYPH_W*GLYPH_H glyph bitmap; row r = bits [W*H-1-W*r -: W]; MSB = leftmost
//   px_valid      out  1               pixel valid
//   px_ready      in   1               downstream accepts the pixel
//   px            out  1               pixel value, 1 = foreground
//   px_last       out  1               marks the final pixel of the current glyph
//   busy          out  1               a glyph is held in the shifter
// BEHAVIOUR
//   Reset values
//   - During rst: px_valid=0, px=0, px_last=0, busy=0, and state = IDLE.
//   - The cycle after rst deasserts, in_ready=1.
//   - Reset mid-glyph discards the glyph; no partial glyph resumes.
//   States
//   - IDLE: in_ready=1, px_valid=0.
//   - SHIFT: px_valid=1. in_ready = px_ready && px_last (combinational), for a zero-bubble chain.
//   Accept (in_valid && in_ready at edge N)
//   - Latch the row slice, scale and invert.
//   - Row slice: if in_row >= GLYPH_H, it is all zeros. If in_code < CODE_MIN, it is all ones.
//     Underline is applied next, then inversion to the whole glyph.
//   - State = SHIFT; the first pixel is valid at cycle N+1.
//   Pixel count
//   - Each glyph emits (GLYPH_W+GAP)*(in_scale+1) pixels.
//   - Column c is held for in_scale+1 consecutive accepted pixels. Gap columns are 0, or 1 if inverted.
//   - Counters: column counter 0..GLYPH_W+GAP-1 and repeat counter 0..in_scale.
//   - Advance only on px_valid && px_ready. px, px_valid and px_last are stable while px_ready=0.
//   - px_last = (column == GLYPH_W+GAP-1) && (repeat == scale).
//   Last pixel
//   - Last pixel accepted and a new request accepted in the same edge: load the new glyph. SHIFT persists.
//   - Last pixel accepted with no new request: state = IDLE.
//   busy = (state == SHIFT).
// TESTING
//   - Row 0 = 10001b, GAP=1, scale 0, px_ready=1: pixels 1,0,0,0,1,0; px_last on pixel 6; px_valid at N+1.
//   - Same glyph with scale 2: 18 pixels 111 000 000 000 111 000. Then invert: 000 111 111 111 000 111.
//   - px_ready toggled randomly: the output sequence matches the no-stall case; px is stable during stalls.
//   - Two requests back to back with in_valid held: 12 contiguous px_valid cycles with no gap; px_last on 6 and 12.
//   - Code 5: pixels 111110. Row 7: 000000. Row 6 with underline: 111110.
//   - rst asserted on pixel 3 of a glyph: px_valid=0 next cycle; in_ready=1 after release; the next glyph starts clean.

Source files
------------

// File: rtl/glyph_row_serializer.sv
// glyph_row_serializer
//   Turns one row of a font glyph into a serial pixel stream for the VGA text
//   console. A request (code, row, scale, invert, underline) is taken on a
//   valid/ready handshake. The glyph bitmap comes from an external
//   combinational ROM addressed directly by in_code. Each glyph emits GLYPH_W
//   pixel columns followed by GAP blank columns. Every column is repeated
//   (in_scale+1) times. Back-to-back requests chain with no idle cycle.
//
//   state | meaning
//   IDLE  | no glyph held, ready for a request, px_valid low
//   SHIFT | a glyph row is being streamed out, px_valid high
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         request handshake
//   in_code, in_row           character code and glyph row (0 = top)
//   in_scale                  horizontal repeat count minus one
//   in_invert, in_underline   per-glyph attributes
//   rom_addr/rom_data         combinational font ROM lookup
//   px_valid/px_ready         pixel stream handshake
//   px, px_last               pixel value and end-of-glyph marker
//   busy                      a glyph is held in the shifter
module glyph_row_serializer #(
    parameter int GLYPH_W  = 5,
    parameter int GLYPH_H  = 7,
    parameter int GAP      = 1,
    parameter int CODE_W   = 7,
    parameter int CODE_MIN = 32,
    parameter int ROW_W    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CODE_W-1:0]            in_code,
    input  logic [ROW_W-1:0]             in_row,
    input  logic [1:0]                   in_scale,
    input  logic                         in_invert,
    input  logic                         in_underline,
    output logic [CODE_W-1:0]            rom_addr,
    input  logic [GLYPH_W*GLYPH_H-1:0]   rom_data,
    output logic                         px_valid,
    input  logic                         px_ready,
    output logic                         px,
    output logic                         px_last,
    output logic                         busy
);

    localparam int COLS  = GLYPH_W + GAP;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_nxt;
    logic [GLYPH_W-1:0] row_q;
    logic [GLYPH_W-1:0] row_bits;
    logic               inv_q;
    logic [1:0]         scale_q;
    logic [COL_W-1:0]   col_q;
    logic [1:0]         rep_q;
    logic               accept;
    logic               px_take;

    assign rom_addr = in_code;

    // Row slice with attribute overrides; inversion last so it also covers
    // the underline and the invalid-code block.
    always_comb begin
        row_bits = '0;
        for (int r = 0; r < GLYPH_H; r++) begin
            if (in_row == ROW_W'(r))
                row_bits = rom_data[GLYPH_W*GLYPH_H-1-GLYPH_W*r -: GLYPH_W];
        end
        if ((in_row < ROW_W'(GLYPH_H)) && (in_code < CODE_W'(CODE_MIN)))
            row_bits = '1;
        if (in_underline && (in_row == ROW_W'(GLYPH_H - 1)))
            row_bits = '1;
        if (in_invert)
            row_bits = ~row_bits;
    end

    always_comb begin
        busy     = (state_q == SHIFT);
        px_valid = busy;
        px_last  = busy && (col_q == LAST_COL) && (rep_q == scale_q);
        // Gap columns carry the inversion flag as their pixel value.
        px       = busy && ((int'(col_q) < GLYPH_W) ? row_q[GLYPH_W-1] : inv_q);
        // In SHIFT the next request is taken on the same edge as the last
        // pixel, which keeps consecutive glyphs bubble-free.
        in_ready = busy ? (px_ready && px_last) : 1'b1;
        accept   = in_valid && in_ready;
        px_take  = px_valid && px_ready;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (px_take && px_last) state_nxt = accept ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            inv_q   <= 1'b0;
            scale_q <= '0;
            col_q   <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                row_q   <= row_bits;
                inv_q   <= in_invert;
                scale_q <= in_scale;
                col_q   <= '0;
                rep_q   <= '0;
            end else if (px_take) begin
                if (rep_q == scale_q) begin
                    rep_q <= '0;
                    row_q <= row_q << 1;
                    col_q <= (col_q == LAST_COL) ? '0 : col_q + 1'b1;
                end else begin
                    rep_q <= rep_q + 1'b1;
                end
            end
        end
    end

endmodule
